// File: rtl/alu_muldiv_iter_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// funct3 encodings, FSM states, and width-generic constants/helpers.
package alu_muldiv_iter_pkg;

    localparam int unsigned MAX_XLEN = 64;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldivState_t;

    // Truncate to XLEN at the point of use.
    localparam logic [MAX_XLEN-1:0] ALL_ONES = '1;

    function automatic logic [MAX_XLEN-1:0] MIN_INT(input int unsigned xlen);
        return MAX_XLEN'(1) << (xlen - 1);
    endfunction

    // Two's-complement magnitude; caller decides whether the operand is negative.
    function automatic logic [MAX_XLEN-1:0] abs_xlen(input logic [MAX_XLEN-1:0] value,
                                                     input logic              negate);
        return negate ? (~value + MAX_XLEN'(1)) : value;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Applies the latched result/remainder signs to the raw unsigned product,
// quotient or remainder and selects the funct3-specific result word.
module muldiv_sign_fix
    import alu_muldiv_iter_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]        funct,
    input  logic [2*XLEN-1:0] product,
    input  logic [XLEN-1:0]   quot,
    input  logic [XLEN-1:0]   rem,
    input  logic              negRes,
    input  logic              negRem,
    output logic [XLEN-1:0]   result_c
);

    logic [2*XLEN-1:0] productFix;
    logic [XLEN-1:0]   quotFix;
    logic [XLEN-1:0]   remFix;

    always_comb begin
        productFix = negRes ? (~product + (2*XLEN)'(1)) : product;
        quotFix    = negRes ? (~quot + XLEN'(1)) : quot;
        remFix     = negRem ? (~rem + XLEN'(1)) : rem;
        result_c   = '0;
        case (funct)
            MUL:                 result_c = productFix[XLEN-1:0];
            MULH, MULHSU, MULHU: result_c = productFix[2*XLEN-1:XLEN];
            DIV, DIVU:           result_c = quotFix;
            REM, REMU:           result_c = remFix;
            default:             result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiply/divide unit beside the execute-stage ALU.
// Optional MULDIV_EARLY_OUT_EN: zero multiplies and |a|<|b| divides finish in one cycle.
module alu_muldiv_iter
    import alu_muldiv_iter_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      functE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] MulDivResult,
    output logic            busy
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT_X  = XLEN'(MIN_INT(XLEN));
    localparam logic [XLEN-1:0] ALL_ONES_X = XLEN'(ALL_ONES);

    muldivState_t      stateQ, stateD;
    logic [CNT_W-1:0]  cntQ, cntD;
    logic [2*XLEN-1:0] accQ, accD;
    logic [XLEN:0]     remQ, remD;
    logic [XLEN-1:0]   opBQ, opBD;
    logic [XLEN-1:0]   resultQ, resultD;
    logic [2:0]        functQ, functD;
    logic              negResQ, negResD;
    logic              negRemQ, negRemD;
    logic              inReadyQ, outValidQ, busyQ;

    // Operand decode at accept time
    logic            accept;
    logic            isMulE, isSignedDivE;
    logic            signA, signB;
    logic [XLEN-1:0] absA, absB;

    assign accept       = in_valid && inReadyQ && !flush;
    assign isMulE       = !functE[2];
    assign isSignedDivE = (functE == DIV) || (functE == REM);
    assign signA = SrcAE[XLEN-1] &&
                   ((functE == MULH) || (functE == MULHSU) || isSignedDivE);
    assign signB = SrcBE[XLEN-1] && ((functE == MULH) || isSignedDivE);
    assign absA  = XLEN'(abs_xlen(MAX_XLEN'(SrcAE), signA));
    assign absB  = XLEN'(abs_xlen(MAX_XLEN'(SrcBE), signB));

    // One shift-add multiply step; low half of accQ holds the multiplier
    logic [XLEN:0]     mulSum;
    logic [2*XLEN-1:0] mulAccNext;

    assign mulSum     = {1'b0, accQ[2*XLEN-1:XLEN]} + {1'b0, opBQ};
    assign mulAccNext = accQ[0] ? {mulSum, accQ[XLEN-1:1]} : {1'b0, accQ[2*XLEN-1:1]};

    // One restoring-division step; low half of accQ holds dividend/quotient.
    // remQ stays below the divisor, so its top bit is always clear on entry.
    logic [XLEN:0]   divShift, divTrial, divRemNext;
    logic            trialOk;
    logic [XLEN-1:0] divQuotNext;

    assign divShift    = (XLEN+1)'({remQ, accQ[XLEN-1]});
    assign divTrial    = divShift - {1'b0, opBQ};
    assign trialOk     = !divTrial[XLEN];
    assign divRemNext  = trialOk ? divTrial : divShift;
    assign divQuotNext = {accQ[XLEN-2:0], trialOk};

    // Final result is formed from the last step's values as CALC exits
    logic [XLEN-1:0] fixedResult;

    muldiv_sign_fix #(
        .XLEN(XLEN)
    ) uSignFix (
        .funct   (functQ),
        .product (mulAccNext),
        .quot    (divQuotNext),
        .rem     (divRemNext[XLEN-1:0]),
        .negRes  (negResQ),
        .negRem  (negRemQ),
        .result_c(fixedResult)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        accD    = accQ;
        remD    = remQ;
        opBD    = opBQ;
        resultD = resultQ;
        functD  = functQ;
        negResD = negResQ;
        negRemD = negRemQ;
        case (stateQ)
            IDLE: begin
                if (accept) begin
                    functD  = functE;
                    negResD = signA ^ signB;
                    negRemD = signA;
                    opBD    = absB;
                    accD    = {XLEN'(0), absA};
                    remD    = '0;
                    cntD    = CNT_W'(XLEN);
                    stateD  = CALC;
                    if (!isMulE && (SrcBE == '0)) begin
                        resultD = functE[1] ? SrcAE : ALL_ONES_X;
                        stateD  = DONE;
                    end else if (isSignedDivE && (SrcAE == MIN_INT_X) &&
                                 (SrcBE == ALL_ONES_X)) begin
                        resultD = functE[1] ? XLEN'(0) : MIN_INT_X;
                        stateD  = DONE;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    else if (isMulE && ((SrcAE == '0) || (SrcBE == '0))) begin
                        resultD = '0;
                        stateD  = DONE;
                    end else if (!isMulE && (absA < absB)) begin
                        resultD = functE[1] ? SrcAE : XLEN'(0);
                        stateD  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    stateD = IDLE;
                end else begin
                    if (functQ[2]) begin
                        accD = {accQ[2*XLEN-1:XLEN], divQuotNext};
                        remD = divRemNext;
                    end else begin
                        accD = mulAccNext;
                    end
                    cntD = cntQ - CNT_W'(1);
                    if (cntQ == CNT_W'(1)) begin
                        resultD = fixedResult;
                        stateD  = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntQ      <= '0;
            accQ      <= '0;
            remQ      <= '0;
            opBQ      <= '0;
            resultQ   <= '0;
            functQ    <= '0;
            negResQ   <= 1'b0;
            negRemQ   <= 1'b0;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            cntQ      <= cntD;
            accQ      <= accD;
            remQ      <= remD;
            opBQ      <= opBD;
            resultQ   <= resultD;
            functQ    <= functD;
            negResQ   <= negResD;
            negRemQ   <= negRemD;
            inReadyQ  <= (stateD == IDLE);
            outValidQ <= (stateD == DONE);
            busyQ     <= (stateD != IDLE);
        end
    end

    assign in_ready     = inReadyQ;
    assign out_valid    = outValidQ;
    assign busy         = busyQ;
    assign MulDivResult = resultQ;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Self-checking bench for alu_muldiv_iter (XLEN=32): vector table, random ops
// against an arithmetic reference model, and handshake/flush/reset sequences.
`timescale 1ns/1ps
module tb_alu_muldiv_iter;

    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int EL = EARLY ? 1 : 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]  functE;
    logic [31:0] SrcAE, SrcBE, MulDivResult;

    alu_muldiv_iter #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .functE(functE), .SrcAE(SrcAE), .SrcBE(SrcBE), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .MulDivResult(MulDivResult), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        else passed++;
    endtask

    function automatic vec_t mk(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input int lat);
        vec_t v;
        v.f = f; v.a = a; v.b = b; v.res = r; v.lat = lat;
        return v;
    endfunction

    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa, sb64;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              sa32, sb32;
        logic [31:0]     r;
        sa = longint'($signed(a)); sb64 = longint'($signed(b));
        ua = 64'(a); ub = 64'(b);
        sa32 = $signed(a); sb32 = $signed(b);
        r = '0;
        case (f)
            F_MUL:    begin p = ua * ub; r = p[31:0]; end
            F_MULH:   begin p = sa * sb64; r = p[63:32]; end
            F_MULHSU: begin p = sa * longint'(ub); r = p[63:32]; end
            F_MULHU:  begin p = ua * ub; r = p[63:32]; end
            F_DIV:    r = (b == 0) ? 32'hFFFF_FFFF :
                          (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa32 / sb32);
            F_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            F_REM:    r = (b == 0) ? a :
                          (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa32 % sb32);
            default:  r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit          sgn;
        logic [31:0] ma, mb;
        sgn = (f == F_DIV) || (f == F_REM);
        if (f[2] && b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (EARLY && !f[2] && (a == 0 || b == 0)) return 1;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (EARLY && f[2] && ma < mb) return 1;
        return 33;
    endfunction

    task automatic waitReady();
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_ready) check("in_ready_timeout", 0, 1);
    endtask

    // Drive one op, push its expectation, then wait for and score the result
    task automatic runOp(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes, input int expLat);
        int          lat;
        logic [31:0] exp;
        waitReady();
        functE = f; SrcAE = a; SrcBE = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        sb.push_back(expRes);
        #1;
        in_valid = 1'b0;
        SrcAE = $urandom; SrcBE = $urandom; functE = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check({name, "_valid"}, 64'(out_valid), 1);
        check({name, "_lat"}, 64'(lat), 64'(expLat));
        exp = (sb.size() != 0) ? sb.pop_front() : ~expRes;
        check({name, "_result"}, 64'(MulDivResult), 64'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [31:0] bpExp;
        bit          saw;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        functE = '0; SrcAE = '0; SrcBE = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_in_ready", 64'(in_ready), 1);
        check("reset_out_valid", 64'(out_valid), 0);
        check("reset_busy", 64'(busy), 0);
        check("reset_result", 64'(MulDivResult), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back(mk(F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33));
        vecs.push_back(mk(F_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33));
        vecs.push_back(mk(F_MULHU,  32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 33));
        vecs.push_back(mk(F_MULHSU, 32'hFFFF_FFF9,  32'd3,         32'hFFFF_FFFF, 33));
        vecs.push_back(mk(F_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33));
        vecs.push_back(mk(F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33));
        vecs.push_back(mk(F_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 33));
        vecs.push_back(mk(F_DIV,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD, 33));
        vecs.push_back(mk(F_REM,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, 33));
        vecs.push_back(mk(F_DIVU,   32'd20,         32'd6,         32'd3,         33));
        vecs.push_back(mk(F_REMU,   32'd20,         32'd6,         32'd2,         33));
        vecs.push_back(mk(F_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33));
        vecs.push_back(mk(F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33));
        vecs.push_back(mk(F_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33));
        vecs.push_back(mk(F_DIVU,   32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1));
        vecs.push_back(mk(F_REMU,   32'h0000_1234,  32'd0,         32'h0000_1234, 1));
        vecs.push_back(mk(F_DIV,    32'd7,          32'd0,         32'hFFFF_FFFF, 1));
        vecs.push_back(mk(F_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1));
        vecs.push_back(mk(F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1));
        vecs.push_back(mk(F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1));
        vecs.push_back(mk(F_MUL,    32'd0,          32'h55,        32'd0,         EL));
        vecs.push_back(mk(F_DIVU,   32'd3,          32'd10,        32'd0,         EL));
        vecs.push_back(mk(F_REM,    32'hFFFF_FFFD,  32'd10,        32'hFFFF_FFFD, EL));

        for (int i = 0; i < vecs.size(); i++)
            runOp($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom);
            a = (i % 7 == 3) ? 32'h8000_0000 : ((i % 9 == 5) ? 32'h0 : $urandom);
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(0, 15);
                2:       b = 32'hFFFF_FFFF;
                default: b = (i % 2 == 0) ? 32'h0 : $urandom_range(1, 100000);
            endcase
            runOp($sformatf("rand%0d", i), f, a, b, refModel(f, a, b), refLatency(f, a, b));
        end

        // Backpressure: result held while out_ready is low, in_valid ignored
        waitReady();
        functE = F_DIVU; SrcAE = 32'd100; SrcBE = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        sb.push_back(32'd14);
        #1 in_valid = 1'b0;
        begin
            int n = 1;
            while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
            check("bp_lat", 64'(n), 33);
        end
        bpExp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_valid%0d", c), 64'(out_valid), 1);
            check($sformatf("bp_result%0d", c), 64'(MulDivResult), 64'(bpExp));
            check($sformatf("bp_in_ready%0d", c), 64'(in_ready), 0);
            in_valid = 1'b1; functE = F_MUL; SrcAE = $urandom; SrcBE = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_post_valid", 64'(out_valid), 0);
        check("bp_post_in_ready", 64'(in_ready), 1);
        check("bp_post_busy", 64'(busy), 0);
        @(posedge clk); #1;
        check("bp_idle_in_ready", 64'(in_ready), 1);

        // flush in the tenth CALC cycle
        functE = F_MUL; SrcAE = 32'd123; SrcBE = 32'd456; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_before", 64'(busy), 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", 64'(out_valid), 0);
        check("flush_in_ready", 64'(in_ready), 1);
        check("flush_busy", 64'(busy), 0);
        saw = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) saw = 1'b1; end
        check("flush_no_result", 64'(saw), 0);

        // flush in IDLE wins over in_valid
        functE = F_DIVU; SrcAE = 32'd9; SrcBE = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_in_ready", 64'(in_ready), 1);
        check("idle_flush_busy", 64'(busy), 0);
        check("idle_flush_valid", 64'(out_valid), 0);

        // Asynchronous reset in the middle of a divide
        functE = F_DIV; SrcAE = 32'd1000; SrcBE = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", 64'(in_ready), 1);
        check("rst_mid_out_valid", 64'(out_valid), 0);
        check("rst_mid_busy", 64'(busy), 0);
        check("rst_mid_result", 64'(MulDivResult), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        runOp("mul5x5", F_MUL, 32'd5, 32'd5, 32'd25, 33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
